packer: RTL
===========

PACKER -- requirements
Module: packer

Interface
REQ-001 SHALL provide parameter unpacked_width_p, default 2, meaning the width of one input lane in bits.
REQ-002 SHALL provide parameter packed_num_p, default 4, meaning the number of lanes per output word (>=2).
REQ-003 SHALL provide parameter packed_width_p, default unpacked_width_p*packed_num_p, meaning the output word width (derived; not overridden).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, asynchronous and active-low: assertion (0) clears state immediately, deassertion is synchronous to clk_i.
REQ-006 unpacked_i  input  unpacked_width_p  input lane data.
REQ-007 valid_i  input  1  unpacked_i/last_i valid.
REQ-008 last_i  input  1  current lane ends a frame; flush the partial word.
REQ-009 ready_o  output  1  block accepts the current lane.
REQ-010 packed_o  output  packed_width_p  packed word; lane 0 in bits [unpacked_width_p-1:0], lane k at offset k*unpacked_width_p.
REQ-011 count_o  output  $clog2(packed_num_p+1)  number of valid lanes in packed_o (1..packed_num_p).
REQ-012 last_o  output  1  packed_o closes a frame (a word completed by last_i).
REQ-013 valid_o  output  1  packed_o/count_o/last_o valid.
REQ-014 ready_i  input  1  downstream accepts the word.

Function
REQ-015 SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-016 SHALL hold an accumulator register, a lane index (0..packed_num_p-1) and an output register (word, count, last, valid).
REQ-017 SHALL write unpacked_i into accumulator lane [lane index] on every in_fire.
REQ-018 SHALL treat an in_fire as completing when lane index == packed_num_p-1 or last_i = 1.
REQ-019 On a completing in_fire, SHALL load the output register next cycle with the accumulator including the current lane, count = lane index+1, last_o = last_i, valid_o = 1.
REQ-020 SHALL drive all lanes above the last written lane to zero in a flushed partial word.
REQ-021 SHALL reset the lane index to 0 and clear the accumulator after a completing in_fire; otherwise SHALL increment the lane index.
REQ-022 SHALL drive ready_o = 1 when the lane is non-completing, or the output register is empty, or out_fire occurs this cycle; otherwise 0.
REQ-023 SHALL sustain one lane per cycle with ready_i held high, i.e. one word every packed_num_p cycles, with no bubble on word boundaries.
REQ-024 Latency: valid_o SHALL rise exactly one cycle after the completing in_fire.
REQ-025 SHALL clear valid_o on out_fire unless a completing in_fire occurs in the same cycle, in which case the new word SHALL replace the old one without a gap.
REQ-026 SHALL hold packed_o, count_o and last_o stable while valid_o = 1 and ready_i = 0.
REQ-027 ready_o SHALL NOT depend combinationally on valid_i; it may depend on ready_i.
REQ-028 last_i with valid_i = 0 SHALL be ignored.

Reset
REQ-029 While reset_i = 0: valid_o = 0, packed_o = 0, count_o = 0, last_o = 0, lane index = 0, accumulator = 0; ready_o SHALL be 1 within one cycle after deassertion.
REQ-030 Reset asserted mid-word SHALL discard the partial word; the first lane after release SHALL be lane 0.

Structure
REQ-031 No shared package required; count widths are localparams derived from parameters.
REQ-032 SHALL instantiate the existing counter_roll as the lane-index counter (max_val_i = packed_num_p-1, up_i = non-completing in_fire, cleared on completion).

Verification (defaults: 2-bit lanes, 4 lanes)
REQ-033 Lanes 1,2,3,0, ready_i = 1 -> one word 0x39, count_o = 4, last_o = 0, valid_o one cycle after 4th lane.
REQ-034 Lanes 3,1 with last_i on 2nd -> packed_o 0x07, count_o = 2, last_o = 1; next lanes 2,2,2,2 -> 0xAA, count 4.
REQ-035 12 back-to-back lanes, ready_i = 1 -> ready_o never drops, three words, valid_o high for 1 cycle every 4.
REQ-036 ready_i = 0 for 10 cycles after first word -> ready_o drops on 4th lane of second word; first word stable; on ready_i = 1 both words delivered in order, no loss.
REQ-037 Reset pulsed after 2 lanes -> outputs 0; next lanes 1,1,1,1 -> 0x55, count 4.
REQ-038 Random valid_i/ready_i, 1000 lanes vs. scoreboard -> every lane delivered once, in order, zero-padded flushes.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared defaults and width helpers for the lane packer.
package packer_pkg;

  localparam int unsigned PACKER_LANE_W_DEF = 2;
  localparam int unsigned PACKER_LANES_DEF  = 4;

  // Bits needed to index n distinct values, never less than one.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packer_counter_roll.sv
// Rolling up-counter: counts 0..max_val_i and wraps, with a synchronous clear.
module counter_roll #(
  parameter int unsigned width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic [width_p-1:0] max_val_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (up_i) begin
      r_cnt <= (r_cnt == max_val_i) ? '0 : r_cnt + 1'b1;
    end
  end

  assign count_o = r_cnt;

endmodule

// File: rtl/packer.sv
// Packs narrow input lanes into wide output words; last_i flushes a zero-padded
// partial word. One-entry output register with full-rate replace on out_fire.
module packer
  import packer_pkg::*;
#(
  parameter int unsigned unpacked_width_p = PACKER_LANE_W_DEF,
  parameter int unsigned packed_num_p     = PACKER_LANES_DEF,
  parameter int unsigned packed_width_p   = unpacked_width_p * packed_num_p
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [unpacked_width_p-1:0]         unpacked_i,
  input  logic                                valid_i,
  input  logic                                last_i,
  output logic                                ready_o,
  output logic [packed_width_p-1:0]           packed_o,
  output logic [$clog2(packed_num_p+1)-1:0]   count_o,
  output logic                                last_o,
  output logic                                valid_o,
  input  logic                                ready_i
);

  localparam int unsigned      idx_w    = cnt_bits(packed_num_p);
  localparam int unsigned      cnt_w    = $clog2(packed_num_p + 1);
  localparam logic [idx_w-1:0] last_idx = idx_w'(packed_num_p - 1);

  logic [idx_w-1:0]          w_idx;
  logic                      w_final_lane;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_complete;
  logic [packed_width_p-1:0] w_acc_cur;

  logic [packed_width_p-1:0] r_acc;
  logic [packed_width_p-1:0] r_word;
  logic [cnt_w-1:0]          r_count;
  logic                      r_last;
  logic                      r_valid;

  assign w_final_lane = (w_idx == last_idx);
  assign w_out_fire   = r_valid & ready_i;

  // last_i is part of the "completing" test so a flush lane is never taken
  // while the output slot is occupied and not draining.
  assign ready_o    = ~(w_final_lane | last_i) | ~r_valid | ready_i;
  assign w_in_fire  = valid_i & ready_o;
  assign w_complete = w_in_fire & (w_final_lane | last_i);

  always_comb begin
    w_acc_cur = r_acc;
    for (int unsigned k = 0; k < packed_num_p; k++) begin
      if (w_idx == idx_w'(k)) begin
        w_acc_cur[k*unpacked_width_p +: unpacked_width_p] = unpacked_i;
      end
    end
  end

  counter_roll #(
    .width_p (idx_w)
  ) u_lane_cnt (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (w_complete),
    .up_i      (w_in_fire & ~w_complete),
    .max_val_i (last_idx),
    .count_o   (w_idx)
  );

  // Clearing on completion keeps upper lanes zero for the next flushed word.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_acc <= '0;
    end else if (w_complete) begin
      r_acc <= '0;
    end else if (w_in_fire) begin
      r_acc <= w_acc_cur;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_word  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_word  <= w_acc_cur;
      r_count <= cnt_w'(w_idx) + cnt_w'(1);
      r_last  <= last_i;
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign packed_o = r_word;
  assign count_o  = r_count;
  assign last_o   = r_last;
  assign valid_o  = r_valid;

endmodule
